// File: rtl/apb_i2c_seq.sv
// apb_i2c_seq: APB master that drives an APB I2C master core through complete
// single-byte register accesses on an I2C device.
//   write: S dev/W, reg, data, P
//   read : S dev/W, reg, Sr dev/R, data (master NACK), P
// Optional feature: define APB_I2C_SEQ_TIMEOUT_EN to bound STATUS polling per
// byte to POLL_MAX reads (timeout -> STOP + core reset, rsp_err=11).
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_ready high only in IDLE
//   req_rnw, req_dev_addr, req_reg_addr, req_wdata   request fields
//   rsp_valid           1-cycle completion pulse
//   rsp_rdata, rsp_err  read byte / status (00 ok, 01 NACK, 10 AL, 11 timeout)
//   PADDR..PENABLE      APB master outputs to the I2C core
//   PRDATA, PREADY      APB slave responses (PSLVERR ignored)
module apb_i2c_seq #(
  parameter logic [15:0] PRESCALE = 16'd99
`ifdef APB_I2C_SEQ_TIMEOUT_EN
  , parameter int unsigned POLL_MAX = 4096
`endif
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_reg_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [11:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [3:0] {
    S_INIT_PRE, S_INIT_CTRL, S_IDLE, S_TX_WR, S_CMD_WR, S_POLL, S_RX_RD,
    S_STOP_WR, S_STOP_POLL, S_DONE
`ifdef APB_I2C_SEQ_TIMEOUT_EN
    , S_TO_STO, S_TO_DIS, S_TO_EN
`endif
  } state_t;

  state_t      r_state;
  logic        r_rnw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg;
  logic [7:0]  r_wdata;
  logic [2:0]  r_step;
`ifdef APB_I2C_SEQ_TIMEOUT_EN
  logic [15:0] r_poll;
`endif

  logic [7:0]  w_tx, w_cmd;
  logic [2:0]  w_last;
  logic        w_rd_op;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_write;
  logic        w_unused_apb;

  assign w_unused_apb = &{1'b0, PSLVERR, PRDATA[31:8]};

  // Byte sequence table; read step 3 is the receive command (no TX byte).
  always_comb begin
    w_tx  = 8'h00;
    w_cmd = 8'h00;
    case ({r_rnw, r_step})
      4'b0_000: begin w_tx = {r_dev, 1'b0}; w_cmd = 8'h90; end
      4'b0_001: begin w_tx = r_reg;         w_cmd = 8'h10; end
      4'b0_010: begin w_tx = r_wdata;       w_cmd = 8'h50; end
      4'b1_000: begin w_tx = {r_dev, 1'b0}; w_cmd = 8'h90; end
      4'b1_001: begin w_tx = r_reg;         w_cmd = 8'h10; end
      4'b1_010: begin w_tx = {r_dev, 1'b1}; w_cmd = 8'h90; end
      4'b1_011: begin w_tx = 8'h00;         w_cmd = 8'h68; end
      default:  begin w_tx = 8'h00;         w_cmd = 8'h00; end
    endcase
  end

  assign w_last  = r_rnw ? 3'd3 : 3'd2;
  assign w_rd_op = r_rnw && (r_step == 3'd3);

  // APB transfer issued by each bus-owning state.
  always_comb begin
    w_addr  = 12'h000;
    w_wdata = 32'h0;
    w_write = 1'b0;
    case (r_state)
      S_INIT_PRE:  begin w_addr = 12'h000; w_wdata = {16'h0, PRESCALE}; w_write = 1'b1; end
      S_INIT_CTRL: begin w_addr = 12'h004; w_wdata = 32'h80;            w_write = 1'b1; end
      S_TX_WR:     begin w_addr = 12'h010; w_wdata = {24'h0, w_tx};     w_write = 1'b1; end
      S_CMD_WR:    begin w_addr = 12'h014; w_wdata = {24'h0, w_cmd};    w_write = 1'b1; end
      S_POLL:      w_addr = 12'h00C;
      S_RX_RD:     w_addr = 12'h008;
      S_STOP_WR:   begin w_addr = 12'h014; w_wdata = 32'h40;            w_write = 1'b1; end
      S_STOP_POLL: w_addr = 12'h00C;
`ifdef APB_I2C_SEQ_TIMEOUT_EN
      S_TO_STO:    begin w_addr = 12'h014; w_wdata = 32'h40;            w_write = 1'b1; end
      S_TO_DIS:    begin w_addr = 12'h004; w_wdata = 32'h00;            w_write = 1'b1; end
      S_TO_EN:     begin w_addr = 12'h004; w_wdata = 32'h80;            w_write = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= S_INIT_PRE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 12'h000;
      PWDATA    <= 32'h0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 2'b00;
      r_rnw     <= 1'b0;
      r_dev     <= 7'h00;
      r_reg     <= 8'h00;
      r_wdata   <= 8'h00;
      r_step    <= 3'd0;
`ifdef APB_I2C_SEQ_TIMEOUT_EN
      r_poll    <= 16'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid && req_ready) begin
          req_ready <= 1'b0;
          r_rnw     <= req_rnw;
          r_dev     <= req_dev_addr;
          r_reg     <= req_reg_addr;
          r_wdata   <= req_wdata;
          r_step    <= 3'd0;
          r_state   <= S_TX_WR;
        end
        S_DONE: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          // PSEL low means the previous transfer just ended: that cycle is the
          // mandatory one-cycle gap, so launch SETUP now.
          if (!PSEL) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= w_addr;
            PWDATA  <= w_wdata;
            PWRITE  <= w_write;
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            case (r_state)
              S_INIT_PRE:  r_state <= S_INIT_CTRL;
              S_INIT_CTRL: begin r_state <= S_IDLE; req_ready <= 1'b1; end
              S_TX_WR:     r_state <= S_CMD_WR;
              S_CMD_WR: begin
                r_state <= S_POLL;
`ifdef APB_I2C_SEQ_TIMEOUT_EN
                r_poll  <= 16'd0;
`endif
              end
              S_POLL: begin
                // AL is checked first so it wins over a same-read TIP=0.
                if (PRDATA[5]) begin
                  rsp_err   <= 2'b10;
                  rsp_rdata <= 8'h00;
                  rsp_valid <= 1'b1;
                  r_state   <= S_DONE;
                end else if (PRDATA[1]) begin
                  r_state <= S_POLL;
`ifdef APB_I2C_SEQ_TIMEOUT_EN
                  if (r_poll == 16'(POLL_MAX - 1)) r_state <= S_TO_STO;
                  else r_poll <= r_poll + 16'd1;
`endif
                end else if (PRDATA[7] && !w_rd_op) begin
                  r_state <= S_STOP_WR;
                end else if (r_step == w_last) begin
                  if (r_rnw) r_state <= S_RX_RD;
                  else begin
                    rsp_err   <= 2'b00;
                    rsp_rdata <= 8'h00;
                    rsp_valid <= 1'b1;
                    r_state   <= S_DONE;
                  end
                end else begin
                  r_step  <= r_step + 3'd1;
                  r_state <= (r_rnw && r_step == 3'd2) ? S_CMD_WR : S_TX_WR;
                end
              end
              S_RX_RD: begin
                rsp_rdata <= PRDATA[7:0];
                rsp_err   <= 2'b00;
                rsp_valid <= 1'b1;
                r_state   <= S_DONE;
              end
              S_STOP_WR: r_state <= S_STOP_POLL;
              S_STOP_POLL: if (!PRDATA[6]) begin
                rsp_rdata <= 8'h00;
                rsp_err   <= 2'b01;
                rsp_valid <= 1'b1;
                r_state   <= S_DONE;
              end
`ifdef APB_I2C_SEQ_TIMEOUT_EN
              S_TO_STO: r_state <= S_TO_DIS;
              S_TO_DIS: r_state <= S_TO_EN;
              S_TO_EN: begin
                rsp_rdata <= 8'h00;
                rsp_err   <= 2'b11;
                rsp_valid <= 1'b1;
                r_state   <= S_DONE;
              end
`endif
              default: r_state <= S_INIT_PRE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
